fltr_run_len: RTL and testbench
===============================

// Module: fltr_run_len
// PURPOSE
//  Run-length measurer directly downstream of the glitch filter stage.
//  - Consumes the filtered 1-bit stream one sample per clock.
//  - Measures the length of each constant-level run.
//  - Emits {level, length, sat} records through a small FIFO with a valid/ready output.
//  - Feeds the software-visible pulse statistics logic.
// PARAMETERS
//  CNT_W  16  run-length counter width; max length = 2**CNT_W-1
//  DEPTH  4   record FIFO depth; power of 2, >= 2
// PORTS
//  clk        in   1              single clock, all logic on posedge
//  reset      in   1              synchronous, active-high reset
//  in         in   1              filtered sample (filter output), sampled every posedge
//  out_ready  in   1              consumer accepts record this cycle
//  out_valid  out  1              record available (FIFO not empty)
//  out_level  out  1              level of the reported run
//  out_len    out  CNT_W          run length in clocks
//  out_sat    out  1              run length saturated (true length >= 2**CNT_W-1)
//  fifo_cnt   out  $clog2(DEPTH)+1  records held
//  ovf        out  1              sticky: a record was dropped on full FIFO
// BEHAVIOUR
//  - Reset (sync, active-high): cur_level=0, run_len=0, sat=0, FIFO empty.
//    Outputs after reset: out_valid=0, out_level=0, out_len=0, out_sat=0, fifo_cnt=0, ovf=0.
//    Reset mid-operation discards any partial run and all queued records; it also clears ovf.
//  - Each posedge, not in reset:
//    - in==cur_level: run_len <= run_len+1, saturating at 2**CNT_W-1; sat <= 1 on reaching max.
//    - in!=cur_level: push {cur_level, run_len, sat}; then cur_level<=in, run_len<=1, sat<=0.
//  - Empty run suppression: if run_len==0 (first sample after reset is 1), nothing is pushed.
//  - Latency: first differing sample sampled at edge k; record visible with out_valid=1 after edge k.
//  - Output handshake:
//    - out_valid = !empty. Record fields are driven from the FIFO head and are stable while out_valid && !out_ready.
//    - Pop occurs when out_valid && out_ready.
//    - Outputs are 0 when the FIFO is empty.
//  - Full FIFO:
//    - Push with no pop: record dropped, ovf <= 1. ovf is sticky until reset.
//    - Push and pop in the same cycle: both happen, fifo_cnt unchanged, no drop.
//  - Pointers: log2(DEPTH) bits, natural wrap-around. fifo_cnt is the exact occupancy 0..DEPTH.
//  - The final run is never emitted until a level change occurs (no flush input).
// CONFIGURATION
//  - RLE_TIMEOUT_EN defined:
//    - When run_len would exceed 2**CNT_W-1, push {cur_level, 2**CNT_W-1, sat=1}.
//    - Then restart the run at run_len=1 with the same level, so long runs emit periodic records.
//    - A level change after a timeout push reports only the residual length, with sat=0.
//  - RLE_TIMEOUT_EN undefined:
//    - Counter holds at max with sat=1.
//    - A single record is emitted at the next level change.
// STRUCTURE
//  - Shared typedefs go in defined.sv:
//    - rle_rec_t: packed struct {logic level; logic [CNT_W-1:0] len; logic sat;}
//    - Width constant RLE_CNT_W_DEF=16.
//  - One sub-module: fltr_rle_fifo.
//    - Synchronous FIFO of rle_rec_t, DEPTH entries.
//    - Ports: push, din, pop, dout, empty, full, count.
//  - Top level: level/run counter, push logic, ovf flag.
// TESTING
//  1. Reset, out_ready=1, in = 0x6,1x3,0x4,1x6,0x4.
//     -> records (0,6,0),(1,3,0),(0,4,0),(1,6,0); each out_valid one cycle after its edge.
//  2. CNT_W=3, in = 1x2,0x10,1x1.
//     - Undefined RLE_TIMEOUT_EN -> (1,2,0),(0,7,1).
//     - Defined RLE_TIMEOUT_EN -> (1,2,0),(0,7,1),(0,3,0).
//  3. DEPTH=4, out_ready=0, in alternates each cycle for 7 edges.
//     -> fifo_cnt=4, ovf=1, the head record stays stable.
//     -> Raise out_ready: 4 records drain, ovf stays 1.
//  4. FIFO full, out_ready=1 on the same cycle as a level change.
//     -> fifo_cnt stays 4, ovf stays 0, both records in order.
//  5. Assert reset for 1 cycle in the middle of a 1x5 run with 2 queued records.
//     -> next cycle out_valid=0, fifo_cnt=0, ovf=0.
//     -> A subsequent 0x3,1x1 yields (0,3,0).
//  6. First sample after reset is 1 (in = 1x3,0x1).
//     -> no empty (0,0) record; first record is (1,3,0).

Source files
------------

// File: rtl/fltr_run_len_pkg.sv
// fltr_run_len_pkg: shared widths and the default-width run record for the run-length measurer
package fltr_run_len_pkg;
  localparam int RLE_CNT_W_DEF = 16;
  localparam int RLE_DEPTH_DEF = 4;
  typedef struct packed {
    logic                     level;
    logic [RLE_CNT_W_DEF-1:0] len;
    logic                     sat;
  } rle_rec_t;
endpackage

// File: rtl/fltr_run_len_if.sv
// fltr_run_len_if: record output channel (out_valid/out_ready, level, len, sat); master drives the record, slave returns ready
interface fltr_run_len_if import fltr_run_len_pkg::*; #(parameter int CNT_W = RLE_CNT_W_DEF);
  logic             out_ready;
  logic             out_valid;
  logic             out_level;
  logic [CNT_W-1:0] out_len;
  logic             out_sat;
  modport master (input out_ready, output out_valid, out_level, out_len, out_sat);
  modport slave (output out_ready, input out_valid, out_level, out_len, out_sat);
endinterface

// File: rtl/fltr_rle_fifo.sv
// fltr_rle_fifo: sync record FIFO (clk, reset, push/din, pop/dout, empty, full, count); dout reads 0 when empty
module fltr_rle_fifo import fltr_run_len_pkg::*; #(
  parameter int W     = RLE_CNT_W_DEF + 2,
  parameter int DEPTH = RLE_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_comb begin
    empty = count == '0;
    full  = count == CW'(DEPTH);
    dout  = empty ? '0 : mem[rp];
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/fltr_run_len.sv
// fltr_run_len: measures constant-level runs of in (clk, reset, in, o record channel, fifo_cnt, sticky ovf); RLE_TIMEOUT_EN splits runs at max length
module fltr_run_len import fltr_run_len_pkg::*; #(
  parameter int CNT_W = RLE_CNT_W_DEF,
  parameter int DEPTH = RLE_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in,
  fltr_run_len_if.master         o,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   ovf
);
  typedef struct packed {
    logic             level;
    logic [CNT_W-1:0] len;
    logic             sat;
  } rec_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  logic             cur_level, sat, diff, at_max, tmo, push_req, push, pop, full, empty;
  logic [CNT_W-1:0] run_len;
  rec_t             rec, head;
  always_comb begin
    diff     = in != cur_level;
    at_max   = run_len == MAX;
`ifdef RLE_TIMEOUT_EN
    tmo      = !diff && at_max;
`else
    tmo      = 1'b0;
`endif
    // a timeout record is {level, MAX, 1}, which is exactly the live state at that moment
    rec      = '{level: cur_level, len: run_len, sat: sat};
    push_req = (diff && run_len != '0) || tmo;
    pop      = !empty && o.out_ready;
    push     = push_req && (!full || pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_level <= 1'b0;
      run_len   <= '0;
      sat       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ovf <= ovf | (push_req && !push);
      if (diff || tmo) begin
        cur_level <= in;
        run_len   <= CNT_W'(1);
        sat       <= 1'b0;
      end else begin
        run_len <= at_max ? MAX : run_len + 1'b1;
        sat     <= sat | (run_len == MAX - 1'b1);
      end
    end
  end
  fltr_rle_fifo #(.W($bits(rec_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (rec),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .count (fifo_cnt)
  );
  assign o.out_valid = !empty;
  assign o.out_level = head.level;
  assign o.out_len   = head.len;
  assign o.out_sat   = head.sat;
endmodule

// File: tb/tb_fltr_run_len.sv
// tb_fltr_run_len: directed checks of the run-length measurer at CNT_W=16 and CNT_W=3
module tb_fltr_run_len;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s = 1'b0;
  logic [2:0] cnt0, cnt1;
  logic       ovf0, ovf1;
  int         tests = 0;
  int         fails = 0;
  fltr_run_len_if #(.CNT_W(16)) if0();
  fltr_run_len_if #(.CNT_W(3))  if1();
  always #5 clk = ~clk;
  fltr_run_len #(.CNT_W(16), .DEPTH(4)) u0 (
    .clk(clk), .reset(rst), .in(s), .o(if0), .fifo_cnt(cnt0), .ovf(ovf0));
  fltr_run_len #(.CNT_W(3), .DEPTH(4)) u1 (
    .clk(clk), .reset(rst), .in(s), .o(if1), .fifo_cnt(cnt1), .ovf(ovf1));

  task automatic run(input logic b, input int n);
    repeat (n) begin
      s = b;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] g0;
    logic [10:0] g1;
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
    do_reset();
    g0 = {if0.out_valid, if0.out_level, if0.out_len, if0.out_sat, cnt0, ovf0};
    tests++;
    if (g0 !== '0) begin fails++; $display("FAIL reset16: got %h want 0", g0); end
    g1 = {if1.out_valid, if1.out_level, if1.out_len, if1.out_sat, cnt1, ovf1};
    tests++;
    if (g1 !== '0) begin fails++; $display("FAIL reset3: got %h want 0", g1); end
  endtask

  task automatic test_stream();
    int lv [5] = '{0, 1, 0, 1, 0};
    int ln [5] = '{6, 3, 4, 6, 4};
    logic [18:0] got, exp;
    if0.out_ready = 1'b1;
    do_reset();
    for (int r = 0; r < 5; r++)
      for (int j = 0; j < ln[r]; j++) begin
        run(1'(lv[r]), 1);
        exp = (j == 0 && r > 0) ? {1'b1, 1'(lv[r-1]), 16'(ln[r-1]), 1'b0} : '0;
        got = {if0.out_valid, if0.out_level, if0.out_len, if0.out_sat};
        tests++;
        if (got !== exp) begin fails++; $display("FAIL stream r%0d j%0d: got %h want %h", r, j, got, exp); end
      end
    tests++;
    if (cnt0 !== 3'd0) begin fails++; $display("FAIL stream_tail cnt: got %0d want 0", cnt0); end
  endtask

  task automatic test_sat();
    logic [4:0] e [3] = '{5'b1_010_0, 5'b0_111_1, 5'b0_011_0};
    logic [5:0] got;
    int n;
`ifdef RLE_TIMEOUT_EN
    n = 3;
`else
    n = 2;
`endif
    if1.out_ready = 1'b0;
    do_reset();
    run(1'b1, 2);
    run(1'b0, 10);
    run(1'b1, 1);
    tests++;
    if (cnt1 !== 3'(n)) begin fails++; $display("FAIL sat cnt: got %0d want %0d", cnt1, n); end
    if1.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      got = {if1.out_valid, if1.out_level, if1.out_len, if1.out_sat};
      tests++;
      if (got !== {1'b1, e[i]}) begin fails++; $display("FAIL sat rec%0d: got %b want %b", i, got, {1'b1, e[i]}); end
      run(1'b1, 1);
    end
    if1.out_ready = 1'b0;
    tests++;
    if (if1.out_valid !== 1'b0) begin fails++; $display("FAIL sat empty: got %b want 0", if1.out_valid); end
  endtask

  task automatic test_overflow();
    logic [18:0] got;
    if0.out_ready = 1'b0;
    do_reset();
    run(1'b0, 1);
    run(1'b1, 1);
    got = {if0.out_valid, if0.out_level, if0.out_len, if0.out_sat};
    tests++;
    if (got !== {1'b1, 1'b0, 16'd1, 1'b0}) begin fails++; $display("FAIL ovf head0: got %h", got); end
    for (int i = 0; i < 5; i++) run(1'(i % 2 == 0 ? 0 : 1), 1);
    tests++;
    if (cnt0 !== 3'd4) begin fails++; $display("FAIL ovf cnt: got %0d want 4", cnt0); end
    tests++;
    if (ovf0 !== 1'b1) begin fails++; $display("FAIL ovf flag: got %b want 1", ovf0); end
    got = {if0.out_valid, if0.out_level, if0.out_len, if0.out_sat};
    tests++;
    if (got !== {1'b1, 1'b0, 16'd1, 1'b0}) begin fails++; $display("FAIL ovf head_stable: got %h", got); end
    if0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got = {if0.out_valid, if0.out_level, if0.out_len, if0.out_sat};
      tests++;
      if (got !== {1'b1, 1'(i % 2), 16'd1, 1'b0}) begin fails++; $display("FAIL ovf drain%0d: got %h", i, got); end
      run(1'b0, 1);
    end
    if0.out_ready = 1'b0;
    tests++;
    if ({cnt0, ovf0} !== 4'b000_1) begin fails++; $display("FAIL ovf after_drain: got cnt %0d ovf %b want 0/1", cnt0, ovf0); end
  endtask

  task automatic test_push_pop_full();
    logic [17:0] e [4] = '{{1'b1, 16'd1, 1'b0}, {1'b0, 16'd1, 1'b0}, {1'b1, 16'd1, 1'b0}, {1'b0, 16'd3, 1'b0}};
    logic [18:0] got;
    if0.out_ready = 1'b0;
    do_reset();
    tests++;
    if (ovf0 !== 1'b0) begin fails++; $display("FAIL full ovf_cleared: got %b want 0", ovf0); end
    for (int i = 0; i < 5; i++) run(1'(i % 2), 1);
    run(1'b0, 2);
    tests++;
    if (cnt0 !== 3'd4) begin fails++; $display("FAIL full cnt_pre: got %0d want 4", cnt0); end
    if0.out_ready = 1'b1;
    run(1'b1, 1);
    tests++;
    if ({cnt0, ovf0} !== 4'b100_0) begin fails++; $display("FAIL full pushpop: got cnt %0d ovf %b want 4/0", cnt0, ovf0); end
    for (int i = 0; i < 4; i++) begin
      got = {if0.out_valid, if0.out_level, if0.out_len, if0.out_sat};
      tests++;
      if (got !== {1'b1, e[i]}) begin fails++; $display("FAIL full drain%0d: got %h want %h", i, got, {1'b1, e[i]}); end
      run(1'b1, 1);
    end
    tests++;
    if ({cnt0, ovf0} !== 4'b000_0) begin fails++; $display("FAIL full end: got cnt %0d ovf %b want 0/0", cnt0, ovf0); end
  endtask

  task automatic test_mid_reset();
    logic [18:0] got;
    if0.out_ready = 1'b0;
    do_reset();
    run(1'b1, 1);
    run(1'b0, 1);
    run(1'b1, 3);
    tests++;
    if (cnt0 !== 3'd2) begin fails++; $display("FAIL midrst cnt_pre: got %0d want 2", cnt0); end
    do_reset();
    tests++;
    if ({if0.out_valid, cnt0, ovf0} !== 5'b0) begin fails++; $display("FAIL midrst cleared: valid %b cnt %0d ovf %b", if0.out_valid, cnt0, ovf0); end
    run(1'b0, 3);
    run(1'b1, 1);
    got = {if0.out_valid, if0.out_level, if0.out_len, if0.out_sat};
    tests++;
    if (got !== {1'b1, 1'b0, 16'd3, 1'b0}) begin fails++; $display("FAIL midrst rec: got %h", got); end
    tests++;
    if (cnt0 !== 3'd1) begin fails++; $display("FAIL midrst cnt: got %0d want 1", cnt0); end
  endtask

  task automatic test_first_one();
    logic [18:0] got;
    if0.out_ready = 1'b0;
    do_reset();
    run(1'b1, 3);
    run(1'b0, 1);
    tests++;
    if (cnt0 !== 3'd1) begin fails++; $display("FAIL first1 cnt: got %0d want 1", cnt0); end
    got = {if0.out_valid, if0.out_level, if0.out_len, if0.out_sat};
    tests++;
    if (got !== {1'b1, 1'b1, 16'd3, 1'b0}) begin fails++; $display("FAIL first1 rec: got %h", got); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_sat();
    test_overflow();
    test_push_pop_full();
    test_mid_reset();
    test_first_one();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
